// File: rtl/rst_sequencer_if.sv
// Handshake bundle between the reset sequencer and the per-domain reset logic.
// The sequencer takes the master modport; the domain/software side takes slave.
interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 8
);
  logic                   SW_RST_REQ;
  logic [CNT_WIDTH-1:0]   Gap_Cycles;
  logic [NUM_DOMAINS-1:0] Domain_Ack;
  logic [NUM_DOMAINS-1:0] Domain_RST_N;
  logic                   Seq_Busy;
  logic                   Seq_Done;
  logic                   Timeout_Err;

  modport master (
    input  SW_RST_REQ, Gap_Cycles, Domain_Ack,
    output Domain_RST_N, Seq_Busy, Seq_Done, Timeout_Err
  );

  modport slave (
    output SW_RST_REQ, Gap_Cycles, Domain_Ack,
    input  Domain_RST_N, Seq_Busy, Seq_Done, Timeout_Err
  );
endinterface

// File: rtl/rst_sequencer.sv
// Releases domain resets one at a time in index order, waiting for each ack plus a gap.
// Optional macro RST_SEQ_REVERSE_ASSERT_EN: software re-reset asserts domains in reverse order.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RST,
  rst_sequencer_if.master seq_io
);

  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_ACK,
    GAP,
    DONE
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    , ASSERT
`endif
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [HOLD_W-1:0]      holdCnt_q;
  logic [TO_W-1:0]        toCnt_q;
  logic [CNT_WIDTH-1:0]   gapCnt_q;
  logic [NUM_DOMAINS-1:0] domRstN_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   tErr_q;

  // A software request outranks every state; in reverse mode it is ignored while already asserting.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      holdCnt_q <= '0;
      toCnt_q   <= '0;
      gapCnt_q  <= '0;
      domRstN_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      tErr_q    <= 1'b0;
    end else if (seq_io.SW_RST_REQ
`ifdef RST_SEQ_REVERSE_ASSERT_EN
                 && (state_q != ASSERT)
`endif
                ) begin
      holdCnt_q <= '0;
      toCnt_q   <= '0;
      tErr_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
      state_q   <= ASSERT;
      idx_q     <= IDX_W'(NUM_DOMAINS - 1);
      gapCnt_q  <= seq_io.Gap_Cycles;
      domRstN_q[NUM_DOMAINS-1] <= 1'b0;
`else
      state_q   <= HOLD;
      idx_q     <= '0;
      gapCnt_q  <= '0;
      domRstN_q <= '0;
`endif
    end else begin
      case (state_q)
        HOLD: begin
          if (holdCnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            domRstN_q[idx_q] <= 1'b1;
            toCnt_q          <= '0;
            state_q          <= WAIT_ACK;
          end else begin
            holdCnt_q <= holdCnt_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (seq_io.Domain_Ack[idx_q]) begin
            gapCnt_q <= seq_io.Gap_Cycles;
            state_q  <= GAP;
          end else if (toCnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
            // A silent domain is left released; the error is reported, not retried.
            tErr_q   <= 1'b1;
            gapCnt_q <= seq_io.Gap_Cycles;
            state_q  <= GAP;
          end else begin
            toCnt_q <= toCnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gapCnt_q != '0) begin
            gapCnt_q <= gapCnt_q - 1'b1;
          end else if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            domRstN_q <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q                   <= idx_q + 1'b1;
            domRstN_q[idx_q + 1'b1] <= 1'b1;
            toCnt_q                 <= '0;
            state_q                 <= WAIT_ACK;
          end
        end
        DONE: begin
          domRstN_q <= '1;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
        // Walk idx downward, dropping one domain per Gap_Cycles+1 edges; domain 0 leads into HOLD.
        ASSERT: begin
          if (gapCnt_q != '0) begin
            gapCnt_q <= gapCnt_q - 1'b1;
          end else if (idx_q == '0) begin
            state_q <= HOLD;
          end else begin
            domRstN_q[idx_q - 1'b1] <= 1'b0;
            if (idx_q == IDX_W'(1)) begin
              idx_q     <= '0;
              gapCnt_q  <= '0;
              holdCnt_q <= '0;
              state_q   <= HOLD;
            end else begin
              idx_q    <= idx_q - 1'b1;
              gapCnt_q <= seq_io.Gap_Cycles;
            end
          end
        end
`endif
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign seq_io.Domain_RST_N = domRstN_q;
  assign seq_io.Seq_Busy     = busy_q;
  assign seq_io.Seq_Done     = done_q;
  assign seq_io.Timeout_Err  = tErr_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: timed tables of expected outputs per sequence edge.
// Edge 0 is the RST release point or the SW_RST_REQ edge that enters HOLD.
module tb_rst_sequencer;

  localparam int ND = 3;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  rst_sequencer_if #(.NUM_DOMAINS(ND), .CNT_WIDTH(CW)) bus ();

  rst_sequencer #(
    .NUM_DOMAINS(ND),
    .CNT_WIDTH  (CW),
    .HOLD_CYCLES(16),
    .ACK_TIMEOUT(64)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .seq_io(bus)
  );

  always #5 CLK = ~CLK;

  // Domain model: ack follows its reset either two cycles late or immediately, gated by a mask.
  logic [ND-1:0] ackD1, ackD2, ackMask;
  logic          instantAck;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ackD1 <= '0;
      ackD2 <= '0;
    end else begin
      ackD1 <= bus.Domain_RST_N;
      ackD2 <= ackD1;
    end
  end

  assign bus.Domain_Ack = (instantAck ? bus.Domain_RST_N : ackD2) & ackMask;

  typedef struct {
    int            atEdge;
    logic [CW-1:0] gap;
    logic [ND-1:0] mask;
    logic [ND-1:0] expRstN;
    logic          expBusy;
    logic          expDone;
    logic          expErr;
  } vec_t;

  vec_t vecs[$];
  int   checks  = 0;
  int   errors  = 0;
  int   curEdge = 0;

  task automatic applyStimulus(input logic [CW-1:0] gap, input logic [ND-1:0] mask);
    bus.Gap_Cycles = gap;
    ackMask        = mask;
  endtask

  task automatic checkOutput(input string name, input logic [ND-1:0] rstN,
                             input logic busy, input logic done, input logic err);
    checks++;
    if (bus.Domain_RST_N !== rstN || bus.Seq_Busy !== busy ||
        bus.Seq_Done !== done || bus.Timeout_Err !== err) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: got rstN=%b busy=%b done=%b err=%b, expected rstN=%b busy=%b done=%b err=%b",
               name, curEdge, bus.Domain_RST_N, bus.Seq_Busy, bus.Seq_Done, bus.Timeout_Err,
               rstN, busy, done, err);
    end
  endtask

  task automatic stepTo(input int target);
    while (curEdge < target) begin
      @(posedge CLK);
      #1;
      curEdge++;
    end
  endtask

  // Pulse the request for one edge; in reverse-assert builds skip ahead to HOLD entry.
  task automatic swRequest();
    bus.SW_RST_REQ = 1'b1;
    @(posedge CLK);
    #1;
    bus.SW_RST_REQ = 1'b0;
    curEdge = 0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    repeat ((ND - 1) * (int'(bus.Gap_Cycles) + 1)) begin
      @(posedge CLK);
      #1;
    end
`endif
  endtask

  task automatic runTable(input string name);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].gap, vecs[i].mask);
      stepTo(vecs[i].atEdge);
      checkOutput($sformatf("%s[%0d]", name, i), vecs[i].expRstN,
                  vecs[i].expBusy, vecs[i].expDone, vecs[i].expErr);
    end
  endtask

  function automatic void addVec(input int e, input logic [CW-1:0] g, input logic [ND-1:0] m,
                                 input logic [ND-1:0] r, input logic b, input logic d,
                                 input logic x);
    vec_t v;
    v.atEdge = e; v.gap = g; v.mask = m;
    v.expRstN = r; v.expBusy = b; v.expDone = d; v.expErr = x;
    vecs.push_back(v);
  endfunction

  // Gap 4, acks two cycles late: releases at 16, 24, 32 and done at 40.
  function automatic void fillNominal();
    vecs.delete();
    addVec( 0, 8'd4, 3'b111, 3'b000, 1, 0, 0);
    addVec(15, 8'd4, 3'b111, 3'b000, 1, 0, 0);
    addVec(16, 8'd4, 3'b111, 3'b001, 1, 0, 0);
    addVec(23, 8'd4, 3'b111, 3'b001, 1, 0, 0);
    addVec(24, 8'd4, 3'b111, 3'b011, 1, 0, 0);
    addVec(31, 8'd4, 3'b111, 3'b011, 1, 0, 0);
    addVec(32, 8'd4, 3'b111, 3'b111, 1, 0, 0);
    addVec(39, 8'd4, 3'b111, 3'b111, 1, 0, 0);
    addVec(40, 8'd4, 3'b111, 3'b111, 0, 1, 0);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.SW_RST_REQ = 1'b0;
    instantAck     = 1'b0;
    applyStimulus(8'd4, 3'b111);

    // Power-on reset values while RST is held low.
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("por", 3'b000, 1, 0, 0);
    @(negedge CLK);
    RST     = 1'b1;
    curEdge = 0;

    fillNominal();
    runTable("nominal");

    // Domain 1 never acks: released at 24, timeout at 88, domain 2 at 93, done at 101.
    vecs.delete();
    addVec(  0, 8'd4, 3'b101, 3'b000, 1, 0, 0);
    addVec( 16, 8'd4, 3'b101, 3'b001, 1, 0, 0);
    addVec( 24, 8'd4, 3'b101, 3'b011, 1, 0, 0);
    addVec( 87, 8'd4, 3'b101, 3'b011, 1, 0, 0);
    addVec( 88, 8'd4, 3'b101, 3'b011, 1, 0, 1);
    addVec( 92, 8'd4, 3'b101, 3'b011, 1, 0, 1);
    addVec( 93, 8'd4, 3'b101, 3'b111, 1, 0, 1);
    addVec(100, 8'd4, 3'b101, 3'b111, 1, 0, 1);
    addVec(101, 8'd4, 3'b101, 3'b111, 0, 1, 1);
    applyStimulus(8'd4, 3'b101);
    swRequest();
    runTable("timeout");

    // Re-sequence from DONE clears the sticky error and repeats nominal timing.
    applyStimulus(8'd4, 3'b111);
    swRequest();
    fillNominal();
    runTable("resequence");

    // Restart while waiting for domain 1's ack.
    swRequest();
    stepTo(25);
    checkOutput("midseq_pre", 3'b011, 1, 0, 0);
    swRequest();
    checkOutput("midseq_req", 3'b000, 1, 0, 0);
    stepTo(15);
    checkOutput("midseq_hold", 3'b000, 1, 0, 0);
    stepTo(16);
    checkOutput("midseq_rel", 3'b001, 1, 0, 0);

    // Zero gap with instant acks: releases two edges apart.
    instantAck = 1'b1;
    vecs.delete();
    addVec(16, 8'd0, 3'b111, 3'b001, 1, 0, 0);
    addVec(17, 8'd0, 3'b111, 3'b001, 1, 0, 0);
    addVec(18, 8'd0, 3'b111, 3'b011, 1, 0, 0);
    addVec(19, 8'd0, 3'b111, 3'b011, 1, 0, 0);
    addVec(20, 8'd0, 3'b111, 3'b111, 1, 0, 0);
    addVec(21, 8'd0, 3'b111, 3'b111, 1, 0, 0);
    addVec(22, 8'd0, 3'b111, 3'b111, 0, 1, 0);
    applyStimulus(8'd0, 3'b111);
    swRequest();
    runTable("zerogap");

`ifdef RST_SEQ_REVERSE_ASSERT_EN
    // Reverse assertion from DONE with gap 2; a second request mid-assert is ignored.
    instantAck = 1'b0;
    applyStimulus(8'd2, 3'b111);
    bus.SW_RST_REQ = 1'b1;
    @(posedge CLK);
    #1;
    bus.SW_RST_REQ = 1'b0;
    curEdge = 0;
    checkOutput("rev_e0", 3'b011, 1, 0, 0);
    stepTo(1);
    bus.SW_RST_REQ = 1'b1;
    stepTo(2);
    bus.SW_RST_REQ = 1'b0;
    checkOutput("rev_e2", 3'b011, 1, 0, 0);
    stepTo(3);
    checkOutput("rev_e3", 3'b001, 1, 0, 0);
    stepTo(5);
    checkOutput("rev_e5", 3'b001, 1, 0, 0);
    stepTo(6);
    checkOutput("rev_e6", 3'b000, 1, 0, 0);
    stepTo(21);
    checkOutput("rev_e21", 3'b000, 1, 0, 0);
    stepTo(22);
    checkOutput("rev_e22", 3'b001, 1, 0, 0);
    instantAck = 1'b1;
    applyStimulus(8'd0, 3'b111);
`endif

    // Asynchronous power-on reset while in GAP.
    swRequest();
    stepTo(17);
    RST = 1'b0;
    #1;
    checkOutput("async_rst", 3'b000, 1, 0, 0);
    stepTo(19);
    checkOutput("rst_held", 3'b000, 1, 0, 0);
    @(negedge CLK);
    RST     = 1'b1;
    curEdge = 0;
    stepTo(16);
    checkOutput("after_rst", 3'b001, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
